elevator_shaft_model: RTL



---
 rtl/elevator_pkg.sv | 36 +++
 rtl/elevator_shaft_model_if.sv | 48 ++++
 rtl/elevator_door_actuator.sv | 111 +++++++++++
 rtl/elevator_shaft_model.sv | 123 ++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared command/sensor encodings and FSM state types for the
// elevator shaft plant model and its door actuator.
package elevator_pkg;

  // Engine command encodings
  localparam logic [1:0] ENGINE_STOP = 2'b00;
  localparam logic [1:0] ENGINE_UP   = 2'b01;
  localparam logic [1:0] ENGINE_DOWN = 2'b10;
  localparam logic [1:0] ENGINE_BAD  = 2'b11;

  // Door command encodings
  localparam logic [1:0] DOOR_HOLD  = 2'b00;
  localparam logic [1:0] DOOR_OPEN  = 2'b01;
  localparam logic [1:0] DOOR_CLOSE = 2'b10;
  localparam logic [1:0] DOOR_BAD   = 2'b11;

  // Door sensor encodings
  localparam logic [1:0] SDOOR_TRANSIT = 2'b00;
  localparam logic [1:0] SDOOR_OPEN    = 2'b01;
  localparam logic [1:0] SDOOR_CLOSED  = 2'b10;
  localparam logic [1:0] SDOOR_OBSTR   = 2'b11;

  typedef enum logic [1:0] {
    MOT_STOP = 2'd0,
    MOT_UP   = 2'd1,
    MOT_DOWN = 2'd2
  } motion_e;

  typedef enum logic [1:0] {
    DS_CLOSED  = 2'd0,
    DS_OPENING = 2'd1,
    DS_OPEN    = 2'd2,
    DS_CLOSING = 2'd3
  } door_state_e;

endpackage

// File: rtl/elevator_shaft_model_if.sv
// elevator_shaft_model_if: controller <-> shaft actuator/sensor bundle.
// master = controller (drives engine/door[/obstruction]), slave = shaft plant.
// Signals: engine[1:0], door[1:0], obstruction (only with
// ELEVATOR_SHAFT_OBSTRUCTION_EN), sensor_up, sensor_down, sensor_door[1:0],
// car_level[LEVEL_W-1:0], at_floor, fault.
interface elevator_shaft_model_if #(
  parameter int unsigned LEVEL_W = 3
);
  logic [1:0]         engine;
  logic [1:0]         door;
`ifdef ELEVATOR_SHAFT_OBSTRUCTION_EN
  logic               obstruction;
`endif
  logic               sensor_up;
  logic               sensor_down;
  logic [1:0]         sensor_door;
  logic [LEVEL_W-1:0] car_level;
  logic               at_floor;
  logic               fault;

  modport master (
    output engine,
    output door,
`ifdef ELEVATOR_SHAFT_OBSTRUCTION_EN
    output obstruction,
`endif
    input  sensor_up,
    input  sensor_down,
    input  sensor_door,
    input  car_level,
    input  at_floor,
    input  fault
  );

  modport slave (
    input  engine,
    input  door,
`ifdef ELEVATOR_SHAFT_OBSTRUCTION_EN
    input  obstruction,
`endif
    output sensor_up,
    output sensor_down,
    output sensor_door,
    output car_level,
    output at_floor,
    output fault
  );
endinterface

// File: rtl/elevator_door_actuator.sv
// elevator_door_actuator: door FSM (CLOSED/OPENING/OPEN/CLOSING) with a
// 0..DOOR_TICKS-1 stroke counter. Mid-stroke reversal mirrors the count.
// Ports: clk, rst_n (async active-low), open_i (accepted open command),
// close_i (close command), obstruction_i (only with
// ELEVATOR_SHAFT_OBSTRUCTION_EN), door_closed_o, sensor_door_o[1:0].
module elevator_door_actuator
  import elevator_pkg::*;
#(
  parameter int unsigned DOOR_TICKS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       open_i,
  input  logic       close_i,
`ifdef ELEVATOR_SHAFT_OBSTRUCTION_EN
  input  logic       obstruction_i,
`endif
  output logic       door_closed_o,
  output logic [1:0] sensor_door_o
);
  localparam int unsigned CNT_W = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DOOR_TICKS - 1);

  door_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sdoor_q, sdoor_d;
  logic             closed_q, closed_d;
  logic             obstr_c;
  logic             bounce;

`ifdef ELEVATOR_SHAFT_OBSTRUCTION_EN
  assign obstr_c = obstruction_i;
`else
  assign obstr_c = 1'b0;
`endif

  // Next-state: stroke progression, reversals and obstruction bounce
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bounce  = 1'b0;
    case (state_q)
      DS_CLOSED: begin
        if (open_i) begin
          state_d = DS_OPENING;
          cnt_d   = '0;
        end
      end
      DS_OPENING: begin
        if (close_i) begin
          state_d = DS_CLOSING;
          cnt_d   = CNT_MAX - cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DS_OPEN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DS_OPEN: begin
        if (close_i) begin
          state_d = DS_CLOSING;
          cnt_d   = '0;
        end
      end
      DS_CLOSING: begin
        if (obstr_c || open_i) begin
          bounce  = obstr_c;
          state_d = DS_OPENING;
          cnt_d   = CNT_MAX - cnt_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d = DS_CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = DS_CLOSED;
        cnt_d   = '0;
      end
    endcase

    closed_d = (state_d == DS_CLOSED);
    case (state_d)
      DS_CLOSED: sdoor_d = SDOOR_CLOSED;
      DS_OPEN:   sdoor_d = SDOOR_OPEN;
      default:   sdoor_d = SDOOR_TRANSIT;
    endcase
    // Obstruction is flagged for the single cycle the door bounces back
    if (bounce) sdoor_d = SDOOR_OBSTR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DS_CLOSED;
      cnt_q    <= '0;
      sdoor_q  <= SDOOR_CLOSED;
      closed_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sdoor_q  <= sdoor_d;
      closed_q <= closed_d;
    end
  end

  assign door_closed_o = closed_q;
  assign sensor_door_o = sdoor_q;

endmodule

// File: rtl/elevator_shaft_model.sv
// elevator_shaft_model: plant model of an elevator shaft. Consumes engine and
// door commands, produces floor-mark pulses, door status and true car
// position, and raises a sticky fault on interlock/overtravel violations.
// Ports: clk, reset (async active-low), sh (slave modport of
// elevator_shaft_model_if). Optional: ELEVATOR_SHAFT_OBSTRUCTION_EN adds the
// obstruction input that bounces a closing door.
module elevator_shaft_model
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS      = 8,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned FLOOR_TICKS = 40,
  parameter int unsigned DOOR_TICKS  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  elevator_shaft_model_if.slave sh
);
  localparam int unsigned SUB_W = (FLOOR_TICKS > 1) ? $clog2(FLOOR_TICKS) : 1;
  localparam logic [SUB_W-1:0]   SUB_MAX = SUB_W'(FLOOR_TICKS - 1);
  localparam logic [LEVEL_W-1:0] TOP_LVL = LEVEL_W'(FLOORS - 1);

  logic [LEVEL_W-1:0] lvl_q, lvl_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic               at_floor_q, at_floor_d;
  logic               up_q, up_d;
  logic               dn_q, dn_d;
  logic               fault_q, fault_d;
  motion_e            mot_c;
  logic               eng_up, eng_dn, eng_move, open_req, close_req;
  logic               move_ok, open_ok, viol;
  logic               door_closed;

  // Interlocks, motion decision and position step
  always_comb begin
    lvl_d = lvl_q;
    sub_d = sub_q;
    up_d  = 1'b0;
    dn_d  = 1'b0;
    mot_c = MOT_STOP;

    eng_up    = (sh.engine == ENGINE_UP);
    eng_dn    = (sh.engine == ENGINE_DOWN);
    eng_move  = eng_up || eng_dn;
    open_req  = (sh.door == DOOR_OPEN);
    close_req = (sh.door == DOOR_CLOSE);

    // A motion request collides with any open request, so both are dropped
    move_ok = eng_move && door_closed && !open_req
              && !(eng_up && (lvl_q == TOP_LVL) && (sub_q == '0))
              && !(eng_dn && (lvl_q == '0) && (sub_q == '0));
    open_ok = open_req && at_floor_q && !eng_move;
    viol    = (sh.engine == ENGINE_BAD) || (sh.door == DOOR_BAD)
              || (eng_move && !move_ok) || (open_req && !open_ok);

    if (move_ok) mot_c = eng_up ? MOT_UP : MOT_DOWN;

    case (mot_c)
      MOT_UP: begin
        if (sub_q == SUB_MAX) begin
          sub_d = '0;
          lvl_d = lvl_q + LEVEL_W'(1);
          up_d  = 1'b1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
      MOT_DOWN: begin
        // Leaving a mark downward: car_level already names the floor below
        if (sub_q == '0) begin
          lvl_d = lvl_q - LEVEL_W'(1);
          sub_d = SUB_MAX;
        end else begin
          sub_d = sub_q - SUB_W'(1);
          dn_d  = (sub_q == SUB_W'(1));
        end
      end
      default: ;
    endcase

    at_floor_d = (sub_d == '0);
    fault_d    = fault_q || viol;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q      <= '0;
      sub_q      <= '0;
      at_floor_q <= 1'b1;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      lvl_q      <= lvl_d;
      sub_q      <= sub_d;
      at_floor_q <= at_floor_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      fault_q    <= fault_d;
    end
  end

  elevator_door_actuator #(
    .DOOR_TICKS(DOOR_TICKS)
  ) u_door (
    .clk          (clk),
    .rst_n        (reset),
    .open_i       (open_ok),
    .close_i      (close_req),
`ifdef ELEVATOR_SHAFT_OBSTRUCTION_EN
    .obstruction_i(sh.obstruction),
`endif
    .door_closed_o(door_closed),
    .sensor_door_o(sh.sensor_door)
  );

  assign sh.car_level   = lvl_q;
  assign sh.at_floor    = at_floor_q;
  assign sh.sensor_up   = up_q;
  assign sh.sensor_down = dn_q;
  assign sh.fault       = fault_q;

endmodule
